// File: rtl/tone_dead_time_driver.sv
// tone_dead_time_driver: complementary high/low gate drive from a tone, with dead time, minimum on-time and fault latch
module tone_dead_time_driver #(
    parameter int DT_WIDTH  = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_i,
    input  logic                 tone_in_i,
    input  logic [DT_WIDTH-1:0]  dead_time_i,
    input  logic [DT_WIDTH-1:0]  min_on_i,
    input  logic                 fault_in_i,
    input  logic                 fault_clear_i,
    output logic                 drv_hi_o,
    output logic                 drv_lo_o,
    output logic                 fault_latched_o,
    output logic [CNT_WIDTH-1:0] hi_pulse_count_o,
    output logic [7:0]           status_o
);
    typedef enum logic [2:0] {OFF = 3'd0, DEAD = 3'd1, LO_ON = 3'd2, HI_ON = 3'd3, FAULT = 3'd4} state_t;

    state_t               state_q, state_d;
    logic                 tone_q;
    logic [1:0]           fault_sync_q;
    logic [DT_WIDTH-1:0]  dead_len_q, dead_cnt_q, on_cnt_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 drv_hi_q, drv_lo_q, fault_latched_q;
    logic [DT_WIDTH-1:0]  dead_eff, min_eff;
    logic                 fault_s, on_done;

    assign fault_s  = fault_sync_q[1];
    assign dead_eff = (dead_time_i == '0) ? DT_WIDTH'(1) : dead_time_i;
    assign min_eff  = (min_on_i == '0) ? DT_WIDTH'(1) : min_on_i;
    // one extra bit so the saturated counter plus one cannot wrap below min_on
    assign on_done  = ({1'b0, on_cnt_q} + (DT_WIDTH + 1)'(1)) >= {1'b0, min_eff};

    // next-state decode: fault beats enable, enable beats the normal switching sequence
    always_comb begin
        state_d = state_q;
        if (fault_s)
            state_d = FAULT;
        else if (state_q == FAULT)
            state_d = fault_clear_i ? OFF : FAULT;
        else if (!enable_i)
            state_d = OFF;
        else begin
            case (state_q)
                OFF:     state_d = DEAD;
                DEAD:    if (dead_cnt_q == dead_len_q - DT_WIDTH'(1)) state_d = tone_q ? HI_ON : LO_ON;
                LO_ON:   if (tone_q && on_done) state_d = DEAD;
                HI_ON:   if (!tone_q && on_done) state_d = DEAD;
                default: state_d = FAULT;
            endcase
        end
    end

    // state, registered drive outputs, input capture and the dead/on/pulse counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= OFF;
            tone_q          <= 1'b0;
            fault_sync_q    <= 2'b00;
            dead_len_q      <= '0;
            dead_cnt_q      <= '0;
            on_cnt_q        <= '0;
            cnt_q           <= '0;
            drv_hi_q        <= 1'b0;
            drv_lo_q        <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            tone_q          <= tone_in_i;
            fault_sync_q    <= {fault_sync_q[0], fault_in_i};
            state_q         <= state_d;
            drv_hi_q        <= state_d == HI_ON;
            drv_lo_q        <= state_d == LO_ON;
            fault_latched_q <= state_d == FAULT;
            if (state_d == DEAD && state_q != DEAD) begin
                dead_len_q <= dead_eff;
                dead_cnt_q <= '0;
            end else if (state_q == DEAD)
                dead_cnt_q <= dead_cnt_q + DT_WIDTH'(1);
            if (state_d != state_q)
                on_cnt_q <= '0;
            else if (on_cnt_q != '1)
                on_cnt_q <= on_cnt_q + DT_WIDTH'(1);
            if (state_d == OFF && !enable_i)
                cnt_q <= '0;
            else if (state_d == HI_ON && state_q != HI_ON)
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign drv_hi_o         = drv_hi_q;
    assign drv_lo_o         = drv_lo_q;
    assign fault_latched_o  = fault_latched_q;
    assign hi_pulse_count_o = cnt_q;
    assign status_o         = {3'b000, tone_q, fault_latched_q, state_q};
endmodule

// File: tb/tb_tone_dead_time_driver.sv
// tb_tone_dead_time_driver: scenario and randomized checks of the gate driver against a cycle-level reference model
module tb_tone_dead_time_driver;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, enable, tone, fault_in, fault_clear;
    logic [15:0]   dead_time, min_on;
    logic          drv_hi, drv_lo, fault_latched;
    logic [CW-1:0] hpc;
    logic [7:0]    status;
    logic [CW+10:0] act;
    int n_tests = 0, n_fail = 0;

    // reference model: mode 0 off, 1 dead, 2 low on, 3 high on, 4 fault
    int     m_mode, m_dead_left, m_on_time, m_count;
    bit     m_tone;
    bit [1:0] m_fs;

    tone_dead_time_driver #(.DT_WIDTH(16), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .enable_i(enable), .tone_in_i(tone),
        .dead_time_i(dead_time), .min_on_i(min_on), .fault_in_i(fault_in),
        .fault_clear_i(fault_clear), .drv_hi_o(drv_hi), .drv_lo_o(drv_lo),
        .fault_latched_o(fault_latched), .hi_pulse_count_o(hpc), .status_o(status)
    );

    always #5 clk = ~clk;
    assign act = {drv_hi, drv_lo, fault_latched, status, hpc};

    function automatic logic [CW+10:0] exp_vec();
        logic [2:0] md;
        md = 3'(m_mode);
        return {m_mode == 3, m_mode == 2, m_mode == 4, 3'b000, m_tone, m_mode == 4, md, CW'(m_count)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_dead_left = 0; m_on_time = 0; m_count = 0; m_tone = 0; m_fs = 2'b00;
    endtask

    task automatic model_step();
        int nm, dl, mo;
        dl = (dead_time == 0) ? 1 : int'(dead_time);
        mo = (min_on == 0) ? 1 : int'(min_on);
        if (m_fs[1]) nm = 4;
        else if (m_mode == 4) nm = fault_clear ? 0 : 4;
        else if (!enable) nm = 0;
        else if (m_mode == 0) nm = 1;
        else if (m_mode == 1) nm = (m_dead_left == 1) ? (m_tone ? 3 : 2) : 1;
        else nm = (m_tone != (m_mode == 3) && m_on_time + 1 >= mo) ? 1 : m_mode;
        if (nm == 1) m_dead_left = (m_mode == 1) ? m_dead_left - 1 : dl;
        m_on_time = (nm == m_mode) ? m_on_time + 1 : 0;
        if (nm == 3 && m_mode != 3) m_count = (m_count + 1) % (1 << CW);
        if (nm == 0 && !enable) m_count = 0;
        m_tone = tone;
        m_fs = {m_fs[0], fault_in};
        m_mode = nm;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; enable = 0; tone = 0; fault_in = 0; fault_clear = 0; dead_time = 4; min_on = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (act !== '0) begin n_fail++; $display("FAIL reset: got %h want 0", act); end
        rst = 0;
    endtask

    task automatic test_dead_entry();
        enable = 1; tone = 0; dead_time = 4; min_on = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_tests++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL dead_entry cyc %0d: got %h want %h", i, act, exp_vec()); end
            if (i == 4) begin
                n_tests++;
                if ({drv_hi, drv_lo} !== 2'b00) begin n_fail++; $display("FAIL dead_entry gap: got %b want 00", {drv_hi, drv_lo}); end
            end
            if (i == 5) begin
                n_tests++;
                if ({drv_hi, drv_lo, hpc} !== {2'b01, CW'(0)}) begin n_fail++; $display("FAIL dead_entry lo_on: got %b/%0d want 01/0", {drv_hi, drv_lo}, hpc); end
            end
        end
    endtask

    task automatic test_square();
        int hi_cyc, both, c0;
        dead_time = 3; min_on = 1; hi_cyc = 0; both = 0; c0 = m_count;
        for (int p = 0; p < 10; p++) begin
            tone = (p % 2 == 0);
            repeat (20) begin
                tick();
                n_tests++;
                if (act !== exp_vec()) begin n_fail++; $display("FAIL square: got %h want %h", act, exp_vec()); end
                hi_cyc += int'(drv_hi);
                both += int'(drv_hi & drv_lo);
            end
        end
        n_tests++;
        if (hi_cyc != 85) begin n_fail++; $display("FAIL square hi_cycles: got %0d want 85", hi_cyc); end
        n_tests++;
        if (both != 0) begin n_fail++; $display("FAIL square overlap: got %0d want 0", both); end
        n_tests++;
        if (hpc !== CW'(c0 + 5)) begin n_fail++; $display("FAIL square count: got %0d want %0d", hpc, CW'(c0 + 5)); end
    endtask

    task automatic test_min_on();
        logic found;
        int c0;
        dead_time = 2; min_on = 10; tone = 0; enable = 0;
        tick();
        n_tests++;
        if (act !== exp_vec()) begin n_fail++; $display("FAIL min_on off: got %h want %h", act, exp_vec()); end
        enable = 1; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            n_tests++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL min_on start: got %h want %h", act, exp_vec()); end
            found = drv_lo;
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL min_on timeout: got drv_lo 0 want 1"); end
        c0 = m_count;
        for (int i = 1; i <= 14; i++) begin
            tone = (i == 9 || i == 10);
            tick();
            n_tests++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL min_on cyc %0d: got %h want %h", i, act, exp_vec()); end
            n_tests++;
            if (drv_hi !== 1'b0 || hpc !== CW'(c0)) begin n_fail++; $display("FAIL min_on absorb cyc %0d: got hi %b cnt %0d want 0/%0d", i, drv_hi, hpc, c0); end
            if (i == 9 || i == 12) begin
                n_tests++;
                if (drv_lo !== 1'b1) begin n_fail++; $display("FAIL min_on lo cyc %0d: got %b want 1", i, drv_lo); end
            end
            if (i == 10 || i == 11) begin
                n_tests++;
                if (drv_lo !== 1'b0) begin n_fail++; $display("FAIL min_on dead cyc %0d: got %b want 0", i, drv_lo); end
            end
        end
    endtask

    task automatic test_fault();
        logic found;
        dead_time = 2; min_on = 1; tone = 1; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            n_tests++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL fault start: got %h want %h", act, exp_vec()); end
            found = drv_hi;
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL fault timeout: got drv_hi 0 want 1"); end
        fault_in = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_tests++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL fault entry cyc %0d: got %h want %h", i, act, exp_vec()); end
        end
        n_tests++;
        if ({drv_hi, drv_lo, fault_latched} !== 3'b001) begin n_fail++; $display("FAIL fault latency: got %b want 001", {drv_hi, drv_lo, fault_latched}); end
        fault_clear = 1;
        tick();
        fault_clear = 0;
        n_tests++;
        if (fault_latched !== 1'b1 || status[2:0] !== 3'd4) begin n_fail++; $display("FAIL fault clear_ignored: got %b/%0d want 1/4", fault_latched, status[2:0]); end
        fault_in = 0;
        repeat (3) begin
            tick();
            n_tests++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL fault hold: got %h want %h", act, exp_vec()); end
        end
        fault_clear = 1;
        tick();
        fault_clear = 0;
        n_tests++;
        if (fault_latched !== 1'b0 || status[2:0] !== 3'd0) begin n_fail++; $display("FAIL fault cleared: got %b/%0d want 0/0", fault_latched, status[2:0]); end
        tick();
        n_tests++;
        if (status[2:0] !== 3'd1) begin n_fail++; $display("FAIL fault restart dead: got %0d want 1", status[2:0]); end
        repeat (2) tick();
        n_tests++;
        if (act !== exp_vec() || drv_hi !== 1'b1) begin n_fail++; $display("FAIL fault resume: got %h want %h", act, exp_vec()); end
    endtask

    task automatic test_wrap();
        int k;
        logic prev;
        dead_time = 1; min_on = 1; tone = 0; enable = 0;
        tick();
        enable = 1;
        repeat (4) tick();
        n_tests++;
        if (act !== exp_vec()) begin n_fail++; $display("FAIL wrap start: got %h want %h", act, exp_vec()); end
        k = 0; prev = drv_hi;
        for (int p = 0; p < 256; p++) begin
            for (int j = 0; j < 8; j++) begin
                tone = (j < 4);
                tick();
                n_tests++;
                if (act !== exp_vec()) begin n_fail++; $display("FAIL wrap: got %h want %h", act, exp_vec()); end
                if (drv_hi && !prev) begin
                    k++;
                    n_tests++;
                    if (hpc !== CW'(k)) begin n_fail++; $display("FAIL wrap count pulse %0d: got %0d want %0d", k, hpc, CW'(k)); end
                end
                prev = drv_hi;
            end
        end
        n_tests++;
        if (k != 256 || hpc !== CW'(0)) begin n_fail++; $display("FAIL wrap final: got %0d pulses cnt %0d want 256/0", k, hpc); end
    endtask

    task automatic test_enable_drop();
        logic found;
        dead_time = 0; min_on = 1; tone = 1; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = drv_hi;
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL enable_drop timeout: got drv_hi 0 want 1"); end
        tone = 0;
        repeat (2) tick();
        n_tests++;
        if (status[2:0] !== 3'd1 || hpc === CW'(0) || act !== exp_vec()) begin n_fail++; $display("FAIL enable_drop in_dead: got %h want %h", act, exp_vec()); end
        enable = 0;
        tick();
        n_tests++;
        if ({drv_hi, drv_lo, status[2:0]} !== 5'b0 || act !== exp_vec()) begin n_fail++; $display("FAIL enable_drop off: got %h want %h", act, exp_vec()); end
        tick();
        n_tests++;
        if (hpc !== CW'(0)) begin n_fail++; $display("FAIL enable_drop count: got %0d want 0", hpc); end
        enable = 1;
    endtask

    task automatic test_async_reset();
        dead_time = 2; min_on = 1; enable = 1; tone = 0;
        repeat (6) tick();
        n_tests++;
        if (drv_lo !== 1'b1 || act !== exp_vec()) begin n_fail++; $display("FAIL async_reset pre: got %h want %h", act, exp_vec()); end
        #2 rst = 1;
        #1;
        n_tests++;
        if (act !== '0) begin n_fail++; $display("FAIL async_reset immediate: got %h want 0", act); end
        model_reset();
        #2 rst = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            n_tests++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL async_reset restart cyc %0d: got %h want %h", i, act, exp_vec()); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) tone = ~tone;
            if ($urandom_range(19) == 0) dead_time = 16'($urandom_range(4));
            if ($urandom_range(19) == 0) min_on = 16'($urandom_range(6));
            enable = ($urandom_range(59) != 0);
            if ($urandom_range(149) == 0) fault_in = ~fault_in;
            fault_clear = ($urandom_range(7) == 0);
            tick();
            n_tests++;
            if (act !== exp_vec()) begin n_fail++; $display("FAIL random cyc %0d: got %h want %h", i, act, exp_vec()); end
            n_tests++;
            if (drv_hi && drv_lo) begin n_fail++; $display("FAIL random overlap cyc %0d: got 11 want not both", i); end
        end
        fault_in = 0;
        fault_clear = 0;
    endtask

    initial begin
        test_reset();
        test_dead_entry();
        test_square();
        test_min_on();
        test_fault();
        test_wrap();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
